// File: rtl/bcd_alu_seq.sv
// rtl/bcd_alu_seq.sv - digit-serial BCD ALU (ADD/SUB decimal, XOR/AND/OR via binary)
// Optional macro BCD_ALU_SAT_EN: overflowing ADD/logic results saturate to all nines.

`ifndef SL_ADD
`define SL_ADD 3'd0
`endif
`ifndef SL_SUB
`define SL_SUB 3'd1
`endif
`ifndef SL_XOR
`define SL_XOR 3'd2
`endif
`ifndef SL_AND
`define SL_AND 3'd3
`endif
`ifndef SL_OR
`define SL_OR 3'd4
`endif

module bcd_alu_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                ovf,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(BIN_W + 1) + 1;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

`ifdef BCD_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDSUB, NEGATE, TOBIN, LOGIC, TOBCD, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, work;
  logic [2:0]      op_r;
  logic            carry;
  logic [BIN_W-1:0] bin_a, bin_b;
  logic [DW-1:0]   bcd;
  logic [CW-1:0]   cnt;

  logic            accept, bad_in, is_sub, last_d, last_b;
  logic [3:0]      x, y, dig;
  logic [4:0]      sum;
  logic [5:0]      diff;
  logic            c_nx;
  logic [W-1:0]    work_nx;
  logic [BIN_W-1:0] bin_a_nx, bin_b_nx, logic_res;
  logic [DW-1:0]   bcd_adj, bcd_nx;
  logic [W-1:0]    fin_result;
  logic            load_out, fin_ovf, fin_neg, fin_err;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic op_valid(input logic [2:0] o);
    return (o == `SL_ADD) || (o == `SL_SUB) || (o == `SL_XOR) ||
           (o == `SL_AND) || (o == `SL_OR);
  endfunction

  assign busy   = (state == ADDSUB) || (state == NEGATE) || (state == TOBIN) ||
                  (state == LOGIC)  || (state == TOBCD);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign bad_in = has_bad_digit(a) || has_bad_digit(b) || !op_valid(op);
  assign is_sub = (state == NEGATE) || (op_r == `SL_SUB);
  assign last_d = (cnt == CW'(DIGITS - 1));
  assign last_b = (cnt == CW'(BIN_W - 1));

  // One decimal digit of add/subtract; NEGATE reuses the subtractor as 0 - x.
  always_comb begin
    x    = a_r[3:0];
    y    = b_r[3:0];
    sum  = '0;
    diff = '0;
    dig  = 4'd0;
    c_nx = 1'b0;
    if (state == NEGATE) begin
      x = 4'd0;
      y = work[3:0];
    end
    if (is_sub) begin
      diff = {2'b00, x} - {2'b00, y} - {5'b00000, carry};
      if (diff[5]) begin
        dig  = 4'(diff + 6'd10);
        c_nx = 1'b1;
      end else begin
        dig  = diff[3:0];
      end
    end else begin
      sum = {1'b0, x} + {1'b0, y} + {4'b0000, carry};
      if (sum > 5'd9) begin
        dig  = 4'(sum - 5'd10);
        c_nx = 1'b1;
      end else begin
        dig  = sum[3:0];
      end
    end
    work_nx = {dig, work[W-1:4]};
  end

  // BCD-to-binary accumulate (MSD first), the logic op, and one double-dabble step.
  always_comb begin
    bin_a_nx = (bin_a << 3) + (bin_a << 1) + BIN_W'(a_r[W-1 -: 4]);
    bin_b_nx = (bin_b << 3) + (bin_b << 1) + BIN_W'(b_r[W-1 -: 4]);
    case (op_r)
      `SL_XOR: logic_res = bin_a ^ bin_b;
      `SL_AND: logic_res = bin_a & bin_b;
      `SL_OR:  logic_res = bin_a | bin_b;
      default: logic_res = '0;
    endcase
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 1; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_nx = {bcd_adj[DW-2:0], bin_a[BIN_W-1]};
  end

  // Next-state logic plus the values captured into the outputs on entry to DONE.
  always_comb begin
    state_nx   = state;
    load_out   = 1'b0;
    fin_result = '0;
    fin_ovf    = 1'b0;
    fin_neg    = 1'b0;
    fin_err    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (accept) begin
          if (bad_in) begin
            state_nx = DONE;
            load_out = 1'b1;
            fin_err  = 1'b1;
          end else if (op == `SL_ADD || op == `SL_SUB) begin
            state_nx = ADDSUB;
          end else begin
            state_nx = TOBIN;
          end
        end
      end
      ADDSUB: begin
        if (last_d) begin
          if (is_sub && c_nx) begin
            state_nx = NEGATE;
          end else begin
            state_nx   = DONE;
            load_out   = 1'b1;
            fin_ovf    = !is_sub && c_nx;
            fin_result = (SAT && fin_ovf) ? ALL9 : work_nx;
          end
        end
      end
      NEGATE: begin
        if (last_d) begin
          state_nx   = DONE;
          load_out   = 1'b1;
          fin_neg    = 1'b1;
          fin_result = work_nx;
        end
      end
      TOBIN:   if (last_d) state_nx = LOGIC;
      LOGIC:   state_nx = TOBCD;
      TOBCD: begin
        if (last_b) begin
          state_nx   = DONE;
          load_out   = 1'b1;
          fin_ovf    = (bcd_nx[DW-1:W] != 4'd0);
          fin_result = (SAT && fin_ovf) ? ALL9 : bcd_nx[W-1:0];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers; rst aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      op_r   <= '0;
      carry  <= 1'b0;
      bin_a  <= '0;
      bin_b  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_out) begin
        result <= fin_result;
        ovf    <= fin_ovf;
        neg    <= fin_neg;
        err    <= fin_err;
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            work  <= '0;
            carry <= 1'b0;
            bin_a <= '0;
            bin_b <= '0;
            bcd   <= '0;
            cnt   <= '0;
          end
        end
        ADDSUB, NEGATE: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          work  <= work_nx;
          carry <= last_d ? 1'b0 : c_nx;
          cnt   <= last_d ? '0 : cnt + 1'b1;
        end
        TOBIN: begin
          a_r   <= a_r << 4;
          b_r   <= b_r << 4;
          bin_a <= bin_a_nx;
          bin_b <= bin_b_nx;
          cnt   <= last_d ? '0 : cnt + 1'b1;
        end
        LOGIC: begin
          bin_a <= logic_res;
          bcd   <= '0;
          cnt   <= '0;
        end
        TOBCD: begin
          bcd   <= bcd_nx;
          bin_a <= bin_a << 1;
          cnt   <= last_b ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb/tb_bcd_alu_seq.sv - directed self-checking bench for bcd_alu_seq (DIGITS=4, BIN_W=14)

`ifndef SL_ADD
`define SL_ADD 3'd0
`endif
`ifndef SL_SUB
`define SL_SUB 3'd1
`endif
`ifndef SL_XOR
`define SL_XOR 3'd2
`endif
`ifndef SL_AND
`define SL_AND 3'd3
`endif
`ifndef SL_OR
`define SL_OR 3'd4
`endif

module tb_bcd_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        busy, done, ovf, neg, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

`ifdef BCD_ALU_SAT_EN
  localparam logic [15:0] WRAP_9999P1 = 16'h9999;
  localparam logic [15:0] WRAP_MAX    = 16'h9999;
  localparam logic [15:0] OR_RES      = 16'h9999;
`else
  localparam logic [15:0] WRAP_9999P1 = 16'h0000;
  localparam logic [15:0] WRAP_MAX    = 16'h9998;
  localparam logic [15:0] OR_RES      = 16'h6383;
`endif

  bcd_alu_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one request at cycle 0 and return in the cycle done is seen (lat = that cycle).
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if ({ovf, neg, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ovf, neg, err}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat; logic bok;
    run_op(`SL_ADD, 16'h1234, 16'h0989, lat, bok);
    checks++; if (result !== 16'h2223) begin errors++; $display("FAIL add_result got %h want 2223", result); end
    checks++; if ({ovf, neg, err} !== 3'b000) begin errors++; $display("FAIL add_flags got %b want 000", {ovf, neg, err}); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got %0d want 5", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL add_busy_cycles got %b want 1", bok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_in_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
    checks++; if (result !== 16'h2223) begin errors++; $display("FAIL result_hold got %h want 2223", result); end
    run_op(`SL_ADD, 16'h9999, 16'h0001, lat, bok);
    checks++; if (result !== WRAP_9999P1) begin errors++; $display("FAIL add_ovf_result got %h want %h", result, WRAP_9999P1); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf_flag got %b want 1", ovf); end
    run_op(`SL_ADD, 16'h9999, 16'h9999, lat, bok);
    checks++; if (result !== WRAP_MAX) begin errors++; $display("FAIL add_max_result got %h want %h", result, WRAP_MAX); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_max_ovf got %b want 1", ovf); end
  endtask

  task automatic test_sub;
    int lat; logic bok;
    run_op(`SL_SUB, 16'h0100, 16'h0250, lat, bok);
    checks++; if (result !== 16'h0150) begin errors++; $display("FAIL sub_neg_result got %h want 0150", result); end
    checks++; if ({ovf, neg, err} !== 3'b010) begin errors++; $display("FAIL sub_neg_flags got %b want 010", {ovf, neg, err}); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL sub_neg_latency got %0d want 9", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL sub_neg_busy got %b want 1", bok); end
    run_op(`SL_SUB, 16'h0250, 16'h0250, lat, bok);
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL sub_eq_result got %h want 0000", result); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL sub_eq_neg got %b want 0", neg); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sub_eq_latency got %0d want 5", lat); end
    run_op(`SL_SUB, 16'h5000, 16'h1234, lat, bok);
    checks++; if (result !== 16'h3766) begin errors++; $display("FAIL sub_pos_result got %h want 3766", result); end
    checks++; if ({ovf, neg} !== 2'b00) begin errors++; $display("FAIL sub_pos_flags got %b want 00", {ovf, neg}); end
    run_op(`SL_SUB, 16'h0000, 16'h0000, lat, bok);
    checks++; if ({result, neg} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL sub_zero got %h/%b want 0000/0", result, neg); end
  endtask

  task automatic test_error;
    int lat; logic bok;
    run_op(`SL_SUB, 16'h0001, 16'h0002, lat, bok);
    run_op(`SL_ADD, 16'h12A4, 16'h0001, lat, bok);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_digit_flag got %b want 1", err); end
    checks++; if ({result, ovf, neg} !== 18'h0) begin errors++; $display("FAIL err_digit_clear got %h/%b%b want 0000/00", result, ovf, neg); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got %0d want 1", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
    run_op(3'd7, 16'h0001, 16'h0002, lat, bok);
    checks++; if ({err, lat == 1} !== 2'b11) begin errors++; $display("FAIL err_op got err=%b lat=%0d want 1/1", err, lat); end
    run_op(`SL_XOR, 16'h0001, 16'h000F, lat, bok);
    checks++; if ({err, result} !== {1'b1, 16'h0}) begin errors++; $display("FAIL err_b_digit got %b/%h want 1/0000", err, result); end
  endtask

  task automatic test_logic;
    int lat; logic bok;
    run_op(`SL_XOR, 16'h0012, 16'h0010, lat, bok);
    checks++; if (result !== 16'h0006) begin errors++; $display("FAIL xor_result got %h want 0006", result); end
    checks++; if ({ovf, neg, err} !== 3'b000) begin errors++; $display("FAIL xor_flags got %b want 000", {ovf, neg, err}); end
    checks++; if (lat !== 20) begin errors++; $display("FAIL xor_latency got %0d want 20", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL xor_busy got %b want 1", bok); end
    run_op(`SL_AND, 16'h1234, 16'h0999, lat, bok);
    checks++; if (result !== 16'h0194) begin errors++; $display("FAIL and_result got %h want 0194", result); end
    run_op(`SL_OR, 16'h9999, 16'h6384, lat, bok);
    checks++; if (result !== OR_RES) begin errors++; $display("FAIL or_result got %h want %h", result, OR_RES); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL or_ovf got %b want 1", ovf); end
  endtask

  task automatic test_abort;
    logic saw_done;
    saw_done = 1'b0;
    op = `SL_SUB; a = 16'h0100; b = 16'h0250; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      if (c == 3) begin op = `SL_ADD; a = 16'h1111; b = 16'h1111; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (c == 5) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
      end
      if (c == 6) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if ({result, ovf, neg, err} !== 19'h0) begin errors++; $display("FAIL abort_outputs got %h/%b%b%b want 0000/000", result, ovf, neg, err); end
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", saw_done); end
  endtask

  task automatic test_back_to_back;
    int lat; logic bok;
    run_op(`SL_ADD, 16'h1234, 16'h0989, lat, bok);
    checks++; if ({result, lat == 5} !== {16'h2223, 1'b1}) begin errors++; $display("FAIL b2b_first got %h lat=%0d want 2223 lat=5", result, lat); end
    op = `SL_SUB; a = 16'h0100; b = 16'h0250; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
    checks++; if ({result, neg} !== {16'h0150, 1'b1}) begin errors++; $display("FAIL b2b_result got %h/%b want 0150/1", result, neg); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_error();
    test_logic();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
